// File: rtl/time_digit_counter_pkg.sv
// rtl/time_digit_counter_pkg.sv - shared constants and digit helpers for the BCD time counter
package time_digit_counter_pkg;

  // Width of one BCD digit and the largest legal digit value
  localparam int DIGIT_W = 4;
  localparam int DIGIT_MAX = 9;

  // Width of the binary value built from the two digits (enough for 0..99 plus illegal codes)
  localparam int VAL_W = 7;

  // Tens digit of a small constant, found by comparison so no divider is needed
  function automatic int tensOf(input int v);
    int t;
    t = 0;
    for (int i = 1; i <= 10; i++) begin
      if (v >= 10 * i) t = i;
    end
    return t;
  endfunction

  // Ones digit of a small constant
  function automatic int onesOf(input int v);
    return v - 10 * tensOf(v);
  endfunction

endpackage

// File: rtl/time_digit_counter_bcd_digit.sv
// rtl/time_digit_counter_bcd_digit.sv - single up/down BCD digit with clear, load and carry/borrow
module bcd_digit
  import time_digit_counter_pkg::*;
#(
  parameter int W = DIGIT_W,
  parameter int MAX = DIGIT_MAX,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         en,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic [W-1:0] digit,
  output logic         carry
);

  localparam logic [W-1:0] MAX_D = W'(MAX);
  localparam logic [W-1:0] RST_D = W'(RST_VAL);

  // Digit register: clear beats load beats step; stepping wraps between 0 and MAX
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      digit <= RST_D;
    end else if (clr) begin
      digit <= RST_D;
    end else if (load) begin
      digit <= loadVal;
    end else if (en) begin
      if (dir) begin
        digit <= (digit == '0) ? MAX_D : digit - 1'b1;
      end else begin
        digit <= (digit == MAX_D) ? '0 : digit + 1'b1;
      end
    end
  end

  // Carry (up) or borrow (down) into the next digit, only while this digit is stepping
  assign carry = en & (dir ? (digit == '0) : (digit == MAX_D));

endmodule

// File: rtl/time_digit_counter.sv
// rtl/time_digit_counter.sv - two-digit BCD modulo counter with load, clear, wrap pulse and terminal count
module time_digit_counter
  import time_digit_counter_pkg::*;
#(
  parameter int MOD = 60,
  parameter int TENS_W = 3,
  parameter int RESET_VAL = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic               DIR,
  input  logic               CLR,
  input  logic               LOAD,
  input  logic [DIGIT_W-1:0] LOAD_ONES,
  input  logic [TENS_W-1:0]  LOAD_TENS,
  output logic [DIGIT_W-1:0] ONES,
  output logic [TENS_W-1:0]  TENS,
  output logic               TC,
  output logic               OVF,
  output logic               LOAD_ERR
);

  // Digits of the top count, used when wrapping downward or recovering from a bad state
  localparam logic [DIGIT_W-1:0] TOP_ONES = DIGIT_W'(onesOf(MOD - 1));
  localparam logic [TENS_W-1:0]  TOP_TENS = TENS_W'(tensOf(MOD - 1));
  localparam logic [VAL_W-1:0]   MOD_V    = VAL_W'(MOD);
  localparam logic [VAL_W-1:0]   TOP_V    = VAL_W'(MOD - 1);
  localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(DIGIT_MAX);

  logic [VAL_W-1:0]   curVal;
  logic [VAL_W-1:0]   loadBin;
  logic               loadOk;
  logic               illegal;
  logic               atTop;
  logic               atZero;
  logic               wrapHit;

  logic               onesEn;
  logic               tensEn;
  logic               onesLoad;
  logic               tensLoad;
  logic [DIGIT_W-1:0] onesLoadVal;
  logic [TENS_W-1:0]  tensLoadVal;
  logic               onesCarry;
  logic               unusedTensCarry;
  logic               wrapNow;
  logic               loadReject;

  // Binary views of the current and requested values for all MOD comparisons
  assign curVal  = VAL_W'(TENS) * VAL_W'(10) + VAL_W'(ONES);
  assign loadBin = VAL_W'(LOAD_TENS) * VAL_W'(10) + VAL_W'(LOAD_ONES);

  assign loadOk  = (LOAD_ONES <= ONES_MAX) && (loadBin < MOD_V);
  assign illegal = (ONES > ONES_MAX) || (curVal >= MOD_V);
  assign atTop   = (curVal == TOP_V);
  assign atZero  = (curVal == '0);
  assign wrapHit = DIR ? atZero : atTop;

  // Terminal count lets the next stage step on the very same edge as this one wraps
  assign TC = EN & ~CLR & ~LOAD & wrapHit;

  // Per-cycle action select: clear, then load, then count; wraps and recovery reuse the digit load path
  always_comb begin
    onesEn      = 1'b0;
    onesLoad    = 1'b0;
    tensLoad    = 1'b0;
    onesLoadVal = '0;
    tensLoadVal = '0;
    wrapNow     = 1'b0;
    loadReject  = 1'b0;
    if (!CLR) begin
      if (LOAD) begin
        if (loadOk) begin
          onesLoad    = 1'b1;
          tensLoad    = 1'b1;
          onesLoadVal = LOAD_ONES;
          tensLoadVal = LOAD_TENS;
        end else begin
          loadReject = 1'b1;
        end
      end else if (EN) begin
        if (illegal || wrapHit) begin
          onesLoad    = 1'b1;
          tensLoad    = 1'b1;
          onesLoadVal = DIR ? TOP_ONES : '0;
          tensLoadVal = DIR ? TOP_TENS : '0;
          wrapNow     = ~illegal;
        end else begin
          onesEn = 1'b1;
        end
      end
    end
  end

  // The tens digit only moves when the ones digit rolls over on a normal step
  assign tensEn = onesEn & onesCarry;

  bcd_digit #(
    .W      (DIGIT_W),
    .MAX    (DIGIT_MAX),
    .RST_VAL(onesOf(RESET_VAL))
  ) onesDigit (
    .clk    (CLK),
    .rstN   (RST_N),
    .en     (onesEn),
    .dir    (DIR),
    .clr    (CLR),
    .load   (onesLoad),
    .loadVal(onesLoadVal),
    .digit  (ONES),
    .carry  (onesCarry)
  );

  // Tens never reaches its own limit while stepping because the MOD wrap is taken first
  bcd_digit #(
    .W      (TENS_W),
    .MAX    (tensOf(MOD - 1)),
    .RST_VAL(tensOf(RESET_VAL))
  ) tensDigit (
    .clk    (CLK),
    .rstN   (RST_N),
    .en     (tensEn),
    .dir    (DIR),
    .clr    (CLR),
    .load   (tensLoad),
    .loadVal(tensLoadVal),
    .digit  (TENS),
    .carry  (unusedTensCarry)
  );

  // Registered one-cycle pulses for a genuine wrap and for a rejected load
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF      <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      OVF      <= wrapNow;
      LOAD_ERR <= loadReject;
    end
  end

endmodule

// File: tb/tb_time_digit_counter.sv
// tb/tb_time_digit_counter.sv - self-checking bench for time_digit_counter
module tb_time_digit_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  logic enA, dirA, clrA, loadA;
  logic [3:0] loA, onesA;
  logic [2:0] ltA, tensA;
  logic tcA, ovfA, lerrA;

  logic clrB, loadB;
  logic [3:0] loB, onesB;
  logic [2:0] ltB, tensB;
  logic tcB, ovfB, lerrB;

  logic enC, dirC, clrC, loadC;
  logic [3:0] loC, onesC;
  logic [2:0] ltC, tensC;
  logic tcC, ovfC, lerrC;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  time_digit_counter #(.MOD(60), .TENS_W(3), .RESET_VAL(0)) dutA (
    .CLK(CLK), .RST_N(RST_N), .EN(enA), .DIR(dirA), .CLR(clrA), .LOAD(loadA),
    .LOAD_ONES(loA), .LOAD_TENS(ltA), .ONES(onesA), .TENS(tensA),
    .TC(tcA), .OVF(ovfA), .LOAD_ERR(lerrA)
  );

  time_digit_counter #(.MOD(60), .TENS_W(3), .RESET_VAL(0)) dutB (
    .CLK(CLK), .RST_N(RST_N), .EN(tcA), .DIR(dirA), .CLR(clrB), .LOAD(loadB),
    .LOAD_ONES(loB), .LOAD_TENS(ltB), .ONES(onesB), .TENS(tensB),
    .TC(tcB), .OVF(ovfB), .LOAD_ERR(lerrB)
  );

  time_digit_counter #(.MOD(24), .TENS_W(3), .RESET_VAL(12)) dutC (
    .CLK(CLK), .RST_N(RST_N), .EN(enC), .DIR(dirC), .CLR(clrC), .LOAD(loadC),
    .LOAD_ONES(loC), .LOAD_TENS(ltC), .ONES(onesC), .TENS(tensC),
    .TC(tcC), .OVF(ovfC), .LOAD_ERR(lerrC)
  );

  typedef struct packed {
    logic [7:0] v;
    logic       ovf;
    logic       lerr;
  } mres_t;

  mres_t mA, mB, mC;

  // Reference behaviour on the plain integer value V
  function automatic mres_t stepFn(int v, int md, int rv, bit clr, bit ld, int lo, int lt, bit en, bit dir);
    mres_t r;
    r.v = 8'(v);
    r.ovf = 1'b0;
    r.lerr = 1'b0;
    if (clr) begin
      r.v = 8'(rv);
    end else if (ld) begin
      if (lo <= 9 && lt * 10 + lo < md) r.v = 8'(lt * 10 + lo);
      else r.lerr = 1'b1;
    end else if (en) begin
      if (!dir) begin
        r.ovf = (v == md - 1);
        r.v = 8'((v + 1) % md);
      end else begin
        r.ovf = (v == 0);
        r.v = 8'((v + md - 1) % md);
      end
    end
    return r;
  endfunction

  function automatic bit tcFn(int v, int md, bit clr, bit ld, bit en, bit dir);
    return en && !clr && !ld && (dir ? (v == 0) : (v == md - 1));
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mA <= {8'd0, 2'b00};
      mB <= {8'd0, 2'b00};
      mC <= {8'd12, 2'b00};
    end else begin
      mA <= stepFn(int'(mA.v), 60, 0, clrA, loadA, int'(loA), int'(ltA), enA, dirA);
      mB <= stepFn(int'(mB.v), 60, 0, clrB, loadB, int'(loB), int'(ltB),
                   tcFn(int'(mA.v), 60, clrA, loadA, enA, dirA), dirA);
      mC <= stepFn(int'(mC.v), 24, 12, clrC, loadC, int'(loC), int'(ltC), enC, dirC);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int valA();
    return 10 * int'(tensA) + int'(onesA);
  endfunction
  function automatic int valB();
    return 10 * int'(tensB) + int'(onesB);
  endfunction
  function automatic int valC();
    return 10 * int'(tensC) + int'(onesC);
  endfunction

  // Every-cycle comparison of all three instances against the model
  initial begin
    forever begin
      @(negedge CLK);
      if (checkEn) begin
        chk("A_ones", int'(onesA), int'(mA.v) % 10);
        chk("A_tens", int'(tensA), int'(mA.v) / 10);
        chk("A_ovf", int'(ovfA), int'(mA.ovf));
        chk("A_lerr", int'(lerrA), int'(mA.lerr));
        chk("A_tc", int'(tcA), int'(tcFn(int'(mA.v), 60, clrA, loadA, enA, dirA)));
        chk("B_ones", int'(onesB), int'(mB.v) % 10);
        chk("B_tens", int'(tensB), int'(mB.v) / 10);
        chk("B_ovf", int'(ovfB), int'(mB.ovf));
        chk("B_lerr", int'(lerrB), int'(mB.lerr));
        chk("B_tc", int'(tcB), int'(tcFn(int'(mB.v), 60, clrB, loadB, bit'(tcA), dirA)));
        chk("C_ones", int'(onesC), int'(mC.v) % 10);
        chk("C_tens", int'(tensC), int'(mC.v) / 10);
        chk("C_ovf", int'(ovfC), int'(mC.ovf));
        chk("C_lerr", int'(lerrC), int'(mC.lerr));
        chk("C_tc", int'(tcC), int'(tcFn(int'(mC.v), 24, clrC, loadC, enC, dirC)));
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    enA = 0; dirA = 0; clrA = 0; loadA = 0; loA = 0; ltA = 0;
    clrB = 0; loadB = 0; loB = 0; ltB = 0;
    enC = 0; dirC = 0; clrC = 0; loadC = 0; loC = 0; ltC = 0;

    #12;
    chk("rst_A_val", valA(), 0);
    chk("rst_A_ovf", int'(ovfA), 0);
    chk("rst_A_lerr", int'(lerrA), 0);
    chk("rst_C_val", valC(), 12);
    tick();
    RST_N = 1'b1;
    checkEn = 1'b1;

    // Count up through a full cycle of 60
    enA = 1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 1) chk("up1_val", valA(), 1);
      if (i == 59) begin
        chk("up59_val", valA(), 59);
        chk("up59_tc", int'(tcA), 1);
        chk("up59_ovf", int'(ovfA), 0);
      end
      if (i == 60) begin
        chk("up60_val", valA(), 0);
        chk("up60_ovf", int'(ovfA), 1);
        chk("up60_B_val", valB(), 1);
      end
    end
    enA = 0;
    tick();
    chk("post_wrap_ovf", int'(ovfA), 0);

    // Hours stage (24) down-wrap from 00
    loadC = 1; loC = 0; ltC = 0;
    tick();
    loadC = 0;
    chk("C_load00", valC(), 0);
    dirC = 1; enC = 1;
    tick();
    enC = 0;
    chk("C_down_wrap_val", valC(), 23);
    chk("C_down_wrap_ovf", int'(ovfC), 1);
    tick();
    chk("C_ovf_drop", int'(ovfC), 0);
    enC = 1;
    tick();
    enC = 0;
    chk("C_down_val", valC(), 22);
    chk("C_down_ovf", int'(ovfC), 0);
    dirC = 0;

    // Hours stage load boundaries, then up-wrap from 23
    loadC = 1; loC = 4; ltC = 2;
    tick();
    chk("C_load24_val", valC(), 22);
    chk("C_load24_err", int'(lerrC), 1);
    loC = 3;
    tick();
    loadC = 0;
    chk("C_load23_val", valC(), 23);
    chk("C_load23_err", int'(lerrC), 0);
    enC = 1;
    tick();
    enC = 0;
    chk("C_up_wrap_val", valC(), 0);
    chk("C_up_wrap_ovf", int'(ovfC), 1);

    // Load validation on the seconds stage
    loadA = 1; loA = 7; ltA = 5;
    tick();
    chk("A_load57_val", valA(), 57);
    chk("A_load57_err", int'(lerrA), 0);
    loA = 6; ltA = 6; enA = 1;
    tick();
    chk("A_load66_val", valA(), 57);
    chk("A_load66_err", int'(lerrA), 1);
    loadA = 0; enA = 0;
    tick();
    chk("A_lerr_drop", int'(lerrA), 0);
    loadA = 1; loA = 4'hA; ltA = 0;
    tick();
    chk("A_loadA_val", valA(), 57);
    chk("A_loadA_err", int'(lerrA), 1);
    loA = 9; ltA = 5;
    tick();
    chk("A_load59_val", valA(), 59);
    loA = 0; ltA = 1;
    tick();
    loadA = 0;
    dirA = 1; enA = 1;
    tick();
    enA = 0;
    chk("A_down10_val", valA(), 9);
    dirA = 0;

    // CLR beats LOAD and EN
    clrC = 1; loadC = 1; loC = 4'hA; ltC = 0; enC = 1;
    tick();
    clrC = 0; loadC = 0; enC = 0;
    chk("C_clr_val", valC(), 12);
    chk("C_clr_ovf", int'(ovfC), 0);
    chk("C_clr_err", int'(lerrC), 0);

    // Cascade 59:59 -> 00:00 on one edge
    loadA = 1; loA = 9; ltA = 5;
    loadB = 1; loB = 9; ltB = 5;
    tick();
    loadA = 0; loadB = 0;
    enA = 1;
    #1;
    chk("casc_tcA", int'(tcA), 1);
    chk("casc_tcB", int'(tcB), 1);
    tick();
    enA = 0;
    chk("casc_A_val", valA(), 0);
    chk("casc_B_val", valB(), 0);
    chk("casc_A_ovf", int'(ovfA), 1);
    chk("casc_B_ovf", int'(ovfB), 1);

    // Asynchronous reset between edges
    loadA = 1; loA = 7; ltA = 3;
    tick();
    loadA = 0;
    chk("A_load37_val", valA(), 37);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_A_val", valA(), 0);
    chk("arst_A_ovf", int'(ovfA), 0);
    chk("arst_C_val", valC(), 12);
    #1;
    RST_N = 1'b1;
    tick();
    enA = 1;
    tick();
    enA = 0;
    chk("resume_A_val", valA(), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
